// File: rtl/instr_reg_sched.sv
// Two-requester instruction scheduler: round-robin grant, registered write to an
// external 32-entry register file, divide-by-zero filtering and a drain FSM.
module instr_reg_sched #(
  parameter int OP_W  = 32,
  parameter int OPC_W = 4,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid0,
  input  logic             valid1,
  input  logic [OP_W-1:0]  opa0,
  input  logic [OP_W-1:0]  opb0,
  input  logic [OP_W-1:0]  opa1,
  input  logic [OP_W-1:0]  opb1,
  input  logic [OPC_W-1:0] opc0,
  input  logic [OPC_W-1:0] opc1,
  output logic             ready0,
  output logic             ready1,
  output logic             load_en,
  output logic [OP_W-1:0]  operand_a,
  output logic [OP_W-1:0]  operand_b,
  output logic [OPC_W-1:0] opcode,
  output logic [AW-1:0]    write_pointer,
  output logic [AW-1:0]    read_pointer,
  input  logic             drain_start,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             drain_busy,
  output logic             drain_done,
  output logic             div0_err
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [OPC_W-1:0] OPC_DIV = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD = OPC_W'(7);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             lastGrant_q, lastGrant_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic             loadEn_q, loadEn_d;
  logic             div0Err_q, div0Err_d;
  logic             drainDone_q, drainDone_d;
  logic [OP_W-1:0]  opA_q, opA_d;
  logic [OP_W-1:0]  opB_q, opB_d;
  logic [OPC_W-1:0] opc_q, opc_d;

  logic [AW+1:0]    occupancy;
  logic             canGrant;
  logic             accept0, accept1, accept;
  logic [OP_W-1:0]  selA, selB;
  logic [OPC_W-1:0] selOpc;
  logic             isDivZero;
  logic             readFire;

  // A pending load already owns a slot, so it counts toward the full check.
  assign occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, loadEn_q};
  assign canGrant  = (occupancy != (AW+2)'(DEPTH));

  // lastGrant_q = 1 means requester 1 won last, so requester 0 wins the next tie.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (canGrant) begin
      if (valid0 && valid1) begin
        ready0 = lastGrant_q;
        ready1 = ~lastGrant_q;
      end else begin
        ready0 = valid0;
        ready1 = valid1;
      end
    end
  end

  assign accept0   = valid0 && ready0;
  assign accept1   = valid1 && ready1;
  assign accept    = accept0 || accept1;
  assign selA      = accept1 ? opa1 : opa0;
  assign selB      = accept1 ? opb1 : opb0;
  assign selOpc    = accept1 ? opc1 : opc0;
  assign isDivZero = ((selOpc == OPC_DIV) || (selOpc == OPC_MOD)) && (selB == '0);

  always_comb begin
    loadEn_d    = accept && !isDivZero;
    div0Err_d   = accept && isDivZero;
    lastGrant_d = accept ? accept1 : lastGrant_q;
    opA_d       = loadEn_d ? selA : opA_q;
    opB_d       = loadEn_d ? selB : opB_q;
    opc_d       = loadEn_d ? selOpc : opc_q;
  end

  assign rd_valid = (state_q == ST_DRAIN) && (count_q != '0);
  assign readFire = rd_valid && rd_ready;

  always_comb begin
    count_d = count_q + {{AW{1'b0}}, loadEn_q} - {{AW{1'b0}}, readFire};
    wrPtr_d = wrPtr_q + {{(AW-1){1'b0}}, loadEn_q};
    rdPtr_d = rdPtr_q + {{(AW-1){1'b0}}, readFire};
  end

  // Draining an empty store finishes at once; otherwise stay until the last read empties it.
  always_comb begin
    state_d     = state_q;
    drainDone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          if ((count_q == '0) && !loadEn_q) begin
            drainDone_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d     = ST_IDLE;
          drainDone_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= 1'b1;
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      loadEn_q    <= 1'b0;
      div0Err_q   <= 1'b0;
      drainDone_q <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      opc_q       <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      count_q     <= count_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      loadEn_q    <= loadEn_d;
      div0Err_q   <= div0Err_d;
      drainDone_q <= drainDone_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      opc_q       <= opc_d;
    end
  end

  assign load_en       = loadEn_q;
  assign operand_a     = opA_q;
  assign operand_b     = opB_q;
  assign opcode        = opc_q;
  assign write_pointer = wrPtr_q;
  assign read_pointer  = rdPtr_q;
  assign count         = count_q;
  assign full          = (count_q == (AW+1)'(DEPTH));
  assign empty         = (count_q == '0);
  assign drain_busy    = (state_q == ST_DRAIN);
  assign drain_done    = drainDone_q;
  assign div0_err      = div0Err_q;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Scoreboard bench for instr_reg_sched: directed stimulus pushes expected grants,
// writes, reads and div0 drops; a negedge monitor pops and compares them.
module tb_instr_reg_sched;

  localparam logic [3:0] ADD   = 4'd3;
  localparam logic [3:0] SUB   = 4'd4;
  localparam logic [3:0] PASSA = 4'd1;
  localparam logic [3:0] PASSB = 4'd2;
  localparam logic [3:0] DIV   = 4'd6;
  localparam logic [3:0] MOD   = 4'd7;

  typedef struct packed {
    logic [4:0]  wp;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        valid0, valid1;
  logic [31:0] opa0, opb0, opa1, opb1;
  logic [3:0]  opc0, opc1;
  logic        ready0, ready1;
  logic        load_en;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  opcode;
  logic [4:0]  write_pointer, read_pointer;
  logic        drain_start, rd_ready, rd_valid;
  logic [5:0]  count;
  logic        full, empty, drain_busy, drain_done, div0_err;

  wr_t expWrQ[$];
  int  expGrantQ[$];
  int  expRdQ[$];
  int  expDivQ[$];
  int  checks;
  int  failures;

  bit rdPat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int expRp [4] = '{0, 1, 1, 2};

  instr_reg_sched dut (
    .clk(clk), .reset_n(reset_n),
    .valid0(valid0), .valid1(valid1),
    .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
    .opc0(opc0), .opc1(opc1),
    .ready0(ready0), .ready1(ready1),
    .load_en(load_en), .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .drain_start(drain_start), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty),
    .drain_busy(drain_busy), .drain_done(drain_done), .div0_err(div0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input int wp, input int a, input int b, input logic [3:0] opc);
    wr_t w;
    w.wp  = 5'(wp);
    w.a   = 32'(a);
    w.b   = 32'(b);
    w.opc = opc;
    expWrQ.push_back(w);
  endtask

  // Drives both requesters for exactly one clock cycle.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input int a0, input int b0, input logic [3:0] c0,
                               input int a1, input int b1, input logic [3:0] c1);
    valid0 = v0; opa0 = 32'(a0); opb0 = 32'(b0); opc0 = c0;
    valid1 = v1; opa1 = 32'(a1); opb1 = 32'(b1); opc1 = c1;
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    valid0 = 1'b0;
    valid1 = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    drain_start = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant, write, read or drop.
  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("oneGrant", 64'(ready0 & ready1), 64'd0);
      checkOutput("ready0NoValid", 64'(ready0 & ~valid0), 64'd0);
      checkOutput("ready1NoValid", 64'(ready1 & ~valid1), 64'd0);
      checkOutput("rdValidIdle", 64'(rd_valid & ~drain_busy), 64'd0);
      if ((valid0 && ready0) || (valid1 && ready1)) begin
        if (expGrantQ.size() == 0) checkOutput("unexpectedGrant", 64'(ready1), 64'd99);
        else checkOutput("grant", 64'(ready1), 64'(expGrantQ.pop_front()));
      end
      if (load_en) begin
        if (expWrQ.size() == 0) begin
          checkOutput("unexpectedLoad", 64'(write_pointer), 64'd99);
        end else begin
          wr_t w;
          w = expWrQ.pop_front();
          checkOutput("writePointer", 64'(write_pointer), 64'(w.wp));
          checkOutput("operandA", 64'(operand_a), 64'(w.a));
          checkOutput("operandB", 64'(operand_b), 64'(w.b));
          checkOutput("opcode", 64'(opcode), 64'(w.opc));
        end
      end
      if (div0_err) begin
        if (expDivQ.size() == 0) checkOutput("unexpectedDiv0", 64'd1, 64'd0);
        else checkOutput("div0Err", 64'(div0_err), 64'(expDivQ.pop_front()));
      end
      if (rd_valid && rd_ready) begin
        if (expRdQ.size() == 0) checkOutput("unexpectedRead", 64'(read_pointer), 64'd99);
        else checkOutput("readPointer", 64'(read_pointer), 64'(expRdQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0; opc0 = '0; opc1 = '0;
    drain_start = 1'b0; rd_ready = 1'b0;

    @(negedge clk);
    checkOutput("rstCount", 64'(count), 64'd0);
    checkOutput("rstEmpty", 64'(empty), 64'd1);
    checkOutput("rstFull", 64'(full), 64'd0);
    checkOutput("rstLoadEn", 64'(load_en), 64'd0);
    checkOutput("rstWritePtr", 64'(write_pointer), 64'd0);
    checkOutput("rstReadPtr", 64'(read_pointer), 64'd0);
    checkOutput("rstDrainBusy", 64'(drain_busy), 64'd0);
    checkOutput("rstOperandA", 64'(operand_a), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    $display("[TB] single write");
    expGrantQ.push_back(0);
    expectWrite(0, 5, 3, ADD);
    applyStimulus(1, 0, 5, 3, ADD, 0, 0, 4'd0);
    idleCycles(2);
    @(negedge clk);
    checkOutput("singleCount", 64'(count), 64'd1);
    checkOutput("singleEmpty", 64'(empty), 64'd0);
    @(posedge clk); #1;

    $display("[TB] contention");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      expGrantQ.push_back(i % 2);
      if (i % 2 == 0) expectWrite(i, 100, 1, ADD);
      else expectWrite(i, 200, 2, SUB);
    end
    repeat (4) applyStimulus(1, 1, 100, 1, ADD, 200, 2, SUB);
    idleCycles(2);
    @(negedge clk);
    checkOutput("contCount", 64'(count), 64'd4);
    checkOutput("contWritePtr", 64'(write_pointer), 64'd4);
    @(posedge clk); #1;

    $display("[TB] divide by zero");
    expGrantQ.push_back(0);
    expDivQ.push_back(1);
    expGrantQ.push_back(1);
    expectWrite(4, 1, 1, ADD);
    applyStimulus(1, 1, 7, 0, DIV, 1, 1, ADD);
    applyStimulus(1, 1, 7, 0, DIV, 1, 1, ADD);
    expGrantQ.push_back(1);
    expectWrite(5, 9, 4, MOD);
    applyStimulus(0, 1, 0, 0, 4'd0, 9, 4, MOD);
    idleCycles(2);
    @(negedge clk);
    checkOutput("div0Count", 64'(count), 64'd6);
    checkOutput("div0WritePtr", 64'(write_pointer), 64'd6);
    @(posedge clk); #1;

    $display("[TB] drain with backpressure");
    resetDut();
    for (int i = 0; i < 3; i++) begin
      expGrantQ.push_back(0);
      expectWrite(i, 10 * (i + 1), 10 * (i + 1) + 1, ADD);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 10 * (i + 1), 10 * (i + 1) + 1, ADD, 0, 0, 4'd0);
    idleCycles(2);
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    expRdQ.push_back(0);
    expRdQ.push_back(1);
    expRdQ.push_back(2);
    for (int i = 0; i < 4; i++) begin
      rd_ready = rdPat[i];
      @(negedge clk);
      checkOutput("drainRdPtr", 64'(read_pointer), 64'(expRp[i]));
      checkOutput("drainRdValid", 64'(rd_valid), 64'd1);
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    @(negedge clk);
    checkOutput("drainDone", 64'(drain_done), 64'd1);
    checkOutput("drainEmpty", 64'(empty), 64'd1);
    checkOutput("drainBusyOff", 64'(drain_busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("drainDonePulse", 64'(drain_done), 64'd0);
    @(posedge clk); #1;

    $display("[TB] drain when empty");
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    @(negedge clk);
    checkOutput("emptyDrainDone", 64'(drain_done), 64'd1);
    checkOutput("emptyDrainRdValid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;

    $display("[TB] reset mid-drain");
    resetDut();
    for (int i = 0; i < 3; i++) begin
      expGrantQ.push_back(0);
      expectWrite(i, 40 + i, 1, ADD);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 40 + i, 1, ADD, 0, 0, 4'd0);
    idleCycles(2);
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    rd_ready = 1'b1;
    expRdQ.push_back(0);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midRstCount", 64'(count), 64'd0);
    checkOutput("midRstRdValid", 64'(rd_valid), 64'd0);
    checkOutput("midRstBusy", 64'(drain_busy), 64'd0);
    checkOutput("midRstDone", 64'(drain_done), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstDone", 64'(drain_done), 64'd0);
    @(posedge clk); #1;
    expGrantQ.push_back(0);
    expectWrite(0, 55, 5, ADD);
    applyStimulus(1, 0, 55, 5, ADD, 0, 0, 4'd0);
    idleCycles(2);

    $display("[TB] fill and wrap");
    resetDut();
    for (int i = 0; i < 32; i++) begin
      expGrantQ.push_back(0);
      expectWrite(i, 1000 + i, 1, PASSA);
      applyStimulus(1, 0, 1000 + i, 1, PASSA, 0, 0, 4'd0);
    end
    valid0 = 1'b1; opa0 = 32'd99; opb0 = 32'd1; opc0 = PASSA;
    valid1 = 1'b1; opa1 = 32'd77; opb1 = 32'd2; opc1 = PASSB;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("fillFull", 64'(full), 64'd1);
    checkOutput("fillCount", 64'(count), 64'd32);
    checkOutput("fillReady0", 64'(ready0), 64'd0);
    checkOutput("fillReady1", 64'(ready1), 64'd0);
    @(posedge clk); #1;
    expGrantQ.push_back(1);
    expectWrite(0, 77, 2, PASSB);
    expRdQ.push_back(0);
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    idleCycles(2);
    @(negedge clk);
    checkOutput("refillCount", 64'(count), 64'd32);
    checkOutput("refillFull", 64'(full), 64'd1);
    checkOutput("refillWritePtr", 64'(write_pointer), 64'd1);
    @(posedge clk); #1;
    resetDut();
    idleCycles(1);

    checkOutput("grantQueueEmpty", 64'(expGrantQ.size()), 64'd0);
    checkOutput("writeQueueEmpty", 64'(expWrQ.size()), 64'd0);
    checkOutput("readQueueEmpty", 64'(expRdQ.size()), 64'd0);
    checkOutput("div0QueueEmpty", 64'(expDivQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_reg_sched.md
INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

Interface
REQ-001 SHALL have parameter OP_W, default 32, operand width in bits (signed).
REQ-002 SHALL have parameter OPC_W, default 4, opcode width; encodings ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-003 SHALL have parameter AW, default 5, register-file address width; DEPTH = 2**AW = 32 entries.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 valid0, valid1  in  1 each  requester k has an instruction offered.
REQ-007 opa0/opa1, opb0/opb1  in  OP_W each  requester k operands.
REQ-008 opc0, opc1  in  OPC_W each  requester k opcode.
REQ-009 ready0, ready1  out  1 each  grant; transfer occurs when valid_k && ready_k.
REQ-010 load_en  out  1  write strobe to register file.
REQ-011 operand_a, operand_b  out  OP_W each; opcode  out  OPC_W  registered write data.
REQ-012 write_pointer, read_pointer  out  AW each  register-file addresses.
REQ-013 drain_start  in  1  pulse; begin draining stored entries.
REQ-014 rd_ready  in  1  sink accepts one entry this cycle.
REQ-015 rd_valid  out  1  entry at read_pointer is valid; sink samples instruction_word.
REQ-016 count  out  AW+1  written, not-yet-drained entries (0..32); full, empty  out  1 each.
REQ-017 drain_busy, drain_done  out  1 each; div0_err  out  1  divide-by-zero drop pulse.

Function
REQ-018 Arbitration SHALL be combinational round-robin: both valid -> grant the requester not granted last; one valid -> grant it; after reset requester 0 has priority.
REQ-019 No grant SHALL be issued when (count + load_en) == 32; ready0 = ready1 = 0 then.
REQ-020 At most one ready SHALL be high per cycle; ready_k SHALL never be high while valid_k is low.
REQ-021 An accepted instruction SHALL appear on operand_a/operand_b/opcode with load_en=1 exactly one cycle after acceptance, with write_pointer = wr_ptr; wr_ptr increments (mod 32) and count increments on that load_en cycle.
REQ-022 Accepted instruction with opcode DIV or MOD and operand b == 0 SHALL be dropped: no load_en, pointer/count unchanged, div0_err=1 for one cycle (the load cycle); round-robin still advances.
REQ-023 Drain FSM states SHALL be IDLE and DRAIN; IDLE->DRAIN on drain_start; drain_start ignored while in DRAIN.
REQ-024 In DRAIN: read_pointer = rd_ptr, rd_valid = (count != 0); on rd_valid && rd_ready rd_ptr increments (mod 32) and count decrements.
REQ-025 DRAIN->IDLE when count reaches 0 after a read, with drain_done=1 for that single cycle; drain_start with count==0 SHALL produce drain_done the next cycle with no rd_valid.
REQ-026 Writes SHALL continue during DRAIN; same-cycle load_en and read leave count unchanged; drain ends only when count is 0.
REQ-027 In IDLE, rd_valid=0 and read_pointer holds rd_ptr.
REQ-028 full = (count==32), empty = (count==0); drain_busy = (state==DRAIN).

Reset
REQ-029 On reset_n low, asynchronously: state IDLE, wr_ptr=rd_ptr=0, count=0, load_en=0, operands/opcode=0, div0_err=0, drain_done=0, priority to requester 0.
REQ-030 Reset mid-drain SHALL abort without drain_done; reset in the acceptance-to-load cycle SHALL suppress that load_en.

Verification
REQ-031 Single write: valid0, opc=ADD, a=5, b=3 -> ready0 same cycle; next cycle load_en=1, write_pointer=0, operand_a=5, operand_b=3; count=1.
REQ-032 Contention: valid0 and valid1 held for 4 cycles -> grants 0,1,0,1; write_pointer 0..3; count=4.
REQ-033 Fill: 32 accepted writes -> full=1, ready0=ready1=0 while valid held; one drained read -> one new grant, write_pointer wraps to 0.
REQ-034 Div by zero: opc=DIV, b=0 -> no load_en, div0_err pulse, count unchanged; opc=MOD, b=4 -> normal load.
REQ-035 Drain with backpressure: 3 entries, drain_start, rd_ready toggling 1,0,1,1 -> read_pointer 0,1,1,2; drain_done after third read; empty=1.
REQ-036 Reset mid-drain after 1 of 3 reads -> count=0, rd_valid=0, no drain_done, next write at write_pointer 0.
